// File: rtl/glyph_stream_if.sv
// glyph_stream_if
//   Bundles the character-request, ROM and pixel-stream signals of the
//   glyph stream controller.
//   slave  : seen by the controller (accepts chars, drives ROM address,
//            sources pixels).
//   master : seen by the surrounding logic (register interface, ROM,
//            LED bit driver).
//   Signals: char_code/char_valid/char_ready  character handshake
//            rom_addr/rom_data                 glyph ROM lookup
//            pix_valid/pix_ready/pix_on/pix_idx pixel stream handshake
//            busy, frame_done                  status
interface glyph_stream_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned GLYPH_W    = 5,
  parameter int unsigned GLYPH_H    = 7
);
  localparam int unsigned NPIX  = GLYPH_W * GLYPH_H;
  localparam int unsigned IDX_W = $clog2(NPIX);

  logic [ADDR_WIDTH-1:0] char_code;
  logic                  char_valid;
  logic                  char_ready;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [NPIX-1:0]       rom_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_on;
  logic [IDX_W-1:0]      pix_idx;
  logic                  busy;
  logic                  frame_done;

  modport slave (
    input  char_code, char_valid, rom_data, pix_ready,
    output char_ready, rom_addr, pix_valid, pix_on, pix_idx, busy, frame_done
  );

  modport master (
    output char_code, char_valid, rom_data, pix_ready,
    input  char_ready, rom_addr, pix_valid, pix_on, pix_idx, busy, frame_done
  );
endinterface

// File: rtl/glyph_stream_ctrl.sv
// glyph_stream_ctrl
//   Sequences a 5x7 character ROM for a WS2812B LED matrix: accepts one
//   character code, looks up its glyph, then streams the glyph one pixel
//   per handshake to the LED bit driver and pulses frame_done.
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-high
//     bus  glyph_stream_if.slave (char handshake, ROM address/data,
//          pixel handshake, busy, frame_done)
//   Optional feature macro: GLYPH_SERPENTINE_EN
//     defined   : boustrophedon matrix, odd rows fetched right-to-left
//     undefined : raster order on every row
module glyph_stream_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned GLYPH_W    = 5,
  parameter int unsigned GLYPH_H    = 7
) (
  input logic           clk,
  input logic           rst,
  glyph_stream_if.slave bus
);
  localparam int unsigned NPIX  = GLYPH_W * GLYPH_H;
  localparam int unsigned IDX_W = $clog2(NPIX);
  localparam int unsigned ROW_W = $clog2(GLYPH_H);
  localparam int unsigned COL_W = $clog2(GLYPH_W);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [NPIX-1:0]       glyph_q,    glyph_d;
  logic [ROW_W-1:0]      row_q,      row_d;
  logic [COL_W-1:0]      col_q,      col_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;

  logic [COL_W-1:0]      pcol;
  logic [IDX_W-1:0]      bit_sel;

  // Physical glyph column for the current pixel; pix_idx itself always
  // advances sequentially along the LED chain.
  always_comb begin
`ifdef GLYPH_SERPENTINE_EN
    pcol = row_q[0] ? (COL_W'(GLYPH_W - 1) - col_q) : col_q;
`else
    pcol = col_q;
`endif
    bit_sel = IDX_W'(row_q * GLYPH_W) + IDX_W'(pcol);
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    glyph_d    = glyph_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.char_valid) begin
          rom_addr_d = bus.char_code;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        glyph_d = bus.rom_data;
        row_d   = '0;
        col_d   = '0;
        idx_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (bus.pix_ready) begin
          if (idx_q == IDX_W'(NPIX - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (col_q == COL_W'(GLYPH_W - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      glyph_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      glyph_q    <= glyph_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.char_ready = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.pix_valid  = (state_q == S_STREAM);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.pix_idx    = idx_q;
  assign bus.rom_addr   = rom_addr_q;
  // Glyph survives into IDLE, so the pixel is qualified with the stream state.
  assign bus.pix_on     = (state_q == S_STREAM) & glyph_q[bit_sel];
endmodule
